// File: rtl/mac_sched_pkg.sv
// Shared types and FP16 helpers for the MAC dot-product scheduler.
package mac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [15:0] FP16_POS_INF   = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF   = 16'hFC00;
    localparam logic [15:0] FP16_EXP_MASK  = 16'h7C00;
    localparam logic [15:0] FP16_MANT_MASK = 16'h03FF;

    function automatic logic fp16_is_zero(input logic [15:0] h);
        return ((h & FP16_EXP_MASK) == 16'h0000) && ((h & FP16_MANT_MASK) == 16'h0000);
    endfunction

    function automatic logic fp16_is_inf(input logic [15:0] h);
        return (h == FP16_POS_INF) || (h == FP16_NEG_INF);
    endfunction

endpackage

// File: rtl/mac_scheduler.sv
// Sequences one external FP16 MAC through a K-element dot product with accumulator feedback.
// Optional build macro MAC_SCHED_ZERO_SKIP_EN: zero operand pairs are consumed without a MAC op.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high
//  FETCH | waiting for an operand pair, op_ready high
//  ISSUE | mac_start pulse, operands presented to the MAC
//  WAIT  | counting down MAC latency, capture result at terminal count
//  RESP  | final sum presented on the result port until accepted
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      cmd_init_acc,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_value,
    input  logic [15:0]      op_weight,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_inf,
    output logic             busy,
    output logic             mac_start,
    output logic [15:0]      mac_in_value,
    output logic [15:0]      mac_weight,
    output logic [15:0]      mac_in_accumulate,
    input  logic [15:0]      mac_out_accumulate
);

    localparam int WAIT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       acc;

    assign res_data = acc;

    always_ff @(posedge clk) begin
        if (RST) begin
            state             <= IDLE;
            cmd_ready         <= 1'b1;
            op_ready          <= 1'b0;
            res_valid         <= 1'b0;
            busy              <= 1'b0;
            mac_start         <= 1'b0;
            mac_in_value      <= '0;
            mac_weight        <= '0;
            mac_in_accumulate <= '0;
            remaining         <= '0;
            wait_cnt          <= '0;
            acc               <= '0;
            res_inf           <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining <= cmd_len;
                        acc       <= cmd_init_acc;
                        res_inf   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state     <= RESP;
                            res_valid <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            op_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (op_valid) begin
`ifdef MAC_SCHED_ZERO_SKIP_EN
                        if (fp16_is_zero(op_value) || fp16_is_zero(op_weight)) begin
                            remaining <= remaining - LEN_W'(1);
                            if (remaining == LEN_W'(1)) begin
                                state     <= RESP;
                                op_ready  <= 1'b0;
                                res_valid <= 1'b1;
                            end
                        end else
`endif
                        begin
                            mac_in_value      <= op_value;
                            mac_weight        <= op_weight;
                            mac_in_accumulate <= acc;
                            mac_start         <= 1'b1;
                            op_ready          <= 1'b0;
                            state             <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_W'(MAC_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    // Terminal count lands on the cycle the MAC result becomes valid.
                    if (wait_cnt == '0) begin
                        acc       <= mac_out_accumulate;
                        res_inf   <= res_inf | fp16_is_inf(mac_out_accumulate);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state     <= RESP;
                            res_valid <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            op_ready <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    op_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// Bench for mac_scheduler: behavioural FP16 MAC with real latency plus a dot-product reference model.
module tb_mac_scheduler;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 3;

    logic             clk;
    logic             RST;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [15:0]      cmd_init_acc;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_value;
    logic [15:0]      op_weight;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_inf;
    logic             busy;
    logic             mac_start;
    logic [15:0]      mac_in_value;
    logic [15:0]      mac_weight;
    logic [15:0]      mac_in_accumulate;
    logic [15:0]      mac_out_accumulate;

    int n_assert = 0;
    int n_fail   = 0;
    int last_lat = 0;

    logic [15:0] q_val[$];
    logic [15:0] q_wt[$];

    mac_scheduler #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_init_acc(cmd_init_acc),
        .op_valid(op_valid), .op_ready(op_ready), .op_value(op_value), .op_weight(op_weight),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_inf(res_inf),
        .busy(busy), .mac_start(mac_start),
        .mac_in_value(mac_in_value), .mac_weight(mac_weight), .mac_in_accumulate(mac_in_accumulate),
        .mac_out_accumulate(mac_out_accumulate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real p2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  ex = int'(h[14:10]);
        real m  = real'(int'(h[9:0]));
        real r;
        if (ex == 0)       r = m * p2(-24);
        else if (ex == 31) r = p2(20);
        else               r = (1.0 + m / 1024.0) * p2(ex - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic int rne(input real x);
        int  f  = $rtoi(x);
        real fr = x - real'(f);
        if (fr > 0.5 || (fr == 0.5 && (f % 2) == 1)) f++;
        return f;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s = (r < 0.0);
        real  a = s ? -r : r;
        int   e = 0;
        int   bits;
        if (a == 0.0) return {s, 15'h0000};
        while (a >= p2(e + 1) && e < 40) e++;
        while (a < p2(e) && e > -40) e--;
        if (e > 15) return {s, 15'h7C00};
        if (e < -14) bits = rne(a * p2(24));
        else         bits = ((e + 15) << 10) + rne(a * p2(10 - e)) - 1024;
        if (bits >= 32'h7C00) bits = 32'h7C00;
        return {s, bits[14:0]};
    endfunction

    function automatic logic [15:0] fp_mac(input logic [15:0] v, input logic [15:0] w, input logic [15:0] c);
        return r2h(h2r(v) * h2r(w) + h2r(c));
    endfunction

    // Stand-in MAC datapath: result appears MAC_LAT cycles after the start pulse, junk before that.
    logic [15:0] mac_pend;
    int          mac_cnt = 0;
    always @(posedge clk) begin
        if (mac_start) begin
            if (MAC_LAT == 1) begin
                mac_out_accumulate <= fp_mac(mac_in_value, mac_weight, mac_in_accumulate);
            end else begin
                mac_pend = fp_mac(mac_in_value, mac_weight, mac_in_accumulate);
                mac_cnt  = MAC_LAT - 1;
                mac_out_accumulate <= 16'hDEAD;
            end
        end else if (mac_cnt > 0) begin
            mac_cnt = mac_cnt - 1;
            if (mac_cnt == 0) mac_out_accumulate <= mac_pend;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fp_zero(input logic [15:0] h);
        return h[14:0] == 15'h0000;
    endfunction

    task automatic ref_model(input int len, input logic [15:0] init,
                             output logic [15:0] acc, output bit inf, output int starts);
        acc = init; inf = 1'b0; starts = 0;
        for (int i = 0; i < len; i++) begin
`ifdef MAC_SCHED_ZERO_SKIP_EN
            if (fp_zero(q_val[i]) || fp_zero(q_wt[i])) continue;
`endif
            acc = fp_mac(q_val[i], q_wt[i], acc);
            if (acc[14:0] == 15'h7C00) inf = 1'b1;
            starts++;
        end
    endtask

    task automatic do_cmd(input string tag, input int len, input logic [15:0] init,
                          input int stall, input bit gaps);
        logic [15:0] exp_acc;
        bit          exp_inf;
        int          exp_starts;
        int          idx, starts, cyc;
        bit          hs;
        ref_model(len, init, exp_acc, exp_inf, exp_starts);
        cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_init_acc = init;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin tick(); cyc++; end
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        idx = 0; starts = 0; cyc = 0;
        while (!res_valid && cyc < 2000) begin
            if (mac_start) starts++;
            op_valid = (idx < len) && (!gaps || $urandom_range(0, 2) != 0);
            if (idx < len) begin op_value = q_val[idx]; op_weight = q_wt[idx]; end
            hs = op_valid && op_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        op_valid = 1'b0;
        last_lat = cyc;
        check({tag, "_res_valid"},  32'(res_valid), 32'd1);
        check({tag, "_res_data"},   32'(res_data),  32'(exp_acc));
        check({tag, "_res_inf"},    32'(res_inf),   32'(exp_inf));
        check({tag, "_mac_starts"}, 32'(starts),    32'(exp_starts));
        check({tag, "_consumed"},   32'(idx),       32'(len));
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_data"},  32'(res_data),  32'(exp_acc));
            check({tag, "_hold_cmdrdy"}, 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_post_valid"},  32'(res_valid), 32'd0);
        check({tag, "_post_cmdrdy"}, 32'(cmd_ready), 32'd1);
        check({tag, "_post_busy"},   32'(busy),      32'd0);
    endtask

    function automatic logic [15:0] rnd_fp(input int elo, input int ehi);
        logic [15:0] h;
        h[15]    = 1'($urandom_range(0, 1));
        h[14:10] = 5'($urandom_range(elo, ehi));
        h[9:0]   = 10'($urandom_range(0, 1023));
        return h;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_init_acc = '0;
        op_valid = 1'b0; op_value = '0; op_weight = '0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_ready",  32'(op_ready),  32'd0);
        check("rst_mac_start", 32'(mac_start), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_inf",   32'(res_inf),   32'd0);
        check("rst_mac_ops",   {mac_in_value, mac_weight}, 32'd0);
        RST = 1'b0;
        tick();

        // single element, latency from command handshake
        q_val = {16'h3C00}; q_wt = {16'h4000};
        do_cmd("t1", 1, 16'h0000, 0, 1'b0);
        check("t1_latency", 32'(last_lat), 32'd5);
        check("t1_value",   32'(res_data), 32'h4000);

        q_val = {16'h3C00, 16'h4000, 16'h3800}; q_wt = {16'h4000, 16'h4000, 16'h4000};
        do_cmd("t2", 3, 16'h0000, 0, 1'b0);
        check("t2_value", 32'(res_data), 32'h4700);

        // zero length: no operand traffic, result immediately
        q_val = {}; q_wt = {};
        cmd_valid = 1'b1; cmd_len = '0; cmd_init_acc = 16'h4200;
        tick();
        cmd_valid = 1'b0;
        check("t3_op_ready",  32'(op_ready),  32'd0);
        check("t3_mac_start", 32'(mac_start), 32'd0);
        check("t3_res_valid", 32'(res_valid), 32'd1);
        check("t3_res_data",  32'(res_data),  32'h4200);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("t3_post_busy", 32'(busy), 32'd0);

        q_val = {16'h3C00}; q_wt = {16'h4000};
        do_cmd("t4", 1, 16'h0000, 5, 1'b0);

        // reset while waiting on the MAC
        q_val = {16'h3C00, 16'h3C00}; q_wt = {16'h4000, 16'h4000};
        cmd_valid = 1'b1; cmd_len = LEN_W'(2); cmd_init_acc = 16'h0000;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_value = 16'h3C00; op_weight = 16'h4000;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        check("t5_busy_pre", 32'(busy), 32'd1);
        RST = 1'b1; tick(); RST = 1'b0;
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_mac_start", 32'(mac_start), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_op_ready",  32'(op_ready),  32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        q_val = {16'h3C00}; q_wt = {16'h4000};
        do_cmd("t5b", 1, 16'h0000, 0, 1'b0);
        check("t5b_value", 32'(res_data), 32'h4000);

        q_val = {16'h7BFF}; q_wt = {16'h3C00};
        do_cmd("t6", 1, 16'h7BFF, 0, 1'b0);
        check("t6_value", 32'(res_data), 32'h7C00);
        check("t6_inf",   32'(res_inf),  32'd1);

        // randomized dot products with operand gaps and result backpressure
        for (int n = 0; n < 10; n++) begin
            int len = $urandom_range(1, 6);
            q_val = {}; q_wt = {};
            for (int i = 0; i < len; i++) begin
                q_val.push_back(rnd_fp(13, 16));
                q_wt.push_back(rnd_fp(13, 16));
            end
            do_cmd($sformatf("rnd%0d", n), len, rnd_fp(10, 16), $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
